input_module_16to304: RTL and testbench

- Receive-side deserializer for the OFDM datapath; the counterpart of the 304-to-16 output serializer.
- Collects 19 consecutive 16-bit chunks from a narrow link and reassembles them into one 304-bit symbol word for downstream processing.
- Valid/ready handshake on the chunk side; valid/ready handshake on the word side; one-cycle `done` pulse per delivered word.

---
 rtl/input_module_16to304.sv | 118 +++++++++++
 tb/tb_input_module_16to304.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_module_16to304.sv
// Receive-side deserializer: gathers NUM_CHUNKS narrow chunks (most-significant
// chunk first) into one wide symbol word, then holds that word until the
// downstream side takes it. Chunk-side and word-side valid/ready handshakes,
// plus a one-cycle done pulse for each word delivered.
module input_module_16to304 #(
    parameter  int CHUNK_W    = 16,
    parameter  int NUM_CHUNKS = 19,
    localparam int WORD_W     = CHUNK_W * NUM_CHUNKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CHUNK_W-1:0] data_in,
    input  logic              abort,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              done,
    output logic [4:0]        chunk_count
);

    // The final chunk is taken straight from data_in when the word completes,
    // so only the first NUM_CHUNKS-1 chunks need to be stored.
    localparam int SHREG_W  = WORD_W - CHUNK_W;
    localparam logic [4:0] LAST_IDX = 5'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [SHREG_W-1:0]  shreg_reg, shreg_next;
    logic [4:0]          count_reg, count_next;
    logic [WORD_W-1:0]   data_out_reg, data_out_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;

    logic [WORD_W-1:0]   shifted;
    logic                accept;

    // Incoming chunk enters at the bottom; earlier chunks move toward the MSBs.
    assign shifted = {shreg_reg, data_in};

    // Back-pressure while a finished word waits; never ready while in reset.
    assign ready_out = reset && (state_reg != HOLD);
    assign accept    = valid_in && ready_out;

    assign data_out    = data_out_reg;
    assign valid_out   = valid_reg;
    assign done        = done_reg;
    assign chunk_count = count_reg;

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            count_reg    <= count_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic: collect chunks, complete a word, hand it off.
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        count_next    = count_reg;
        data_out_next = data_out_reg;
        valid_next    = valid_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE, COLLECT: begin
                if (abort) begin
                    // Abort wins over a simultaneous chunk; that chunk is dropped.
                    state_next = IDLE;
                    shreg_next = '0;
                    count_next = '0;
                end else if (accept) begin
                    shreg_next = shifted[SHREG_W-1:0];
                    if (count_reg == LAST_IDX) begin
                        data_out_next = shifted;
                        valid_next    = 1'b1;
                        count_next    = '0;
                        state_next    = HOLD;
                    end else begin
                        count_next = count_reg + 5'd1;
                        state_next = COLLECT;
                    end
                end
            end
            HOLD: begin
                // Abort is ignored here: a completed word is always delivered.
                if (ready_in) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_input_module_16to304.sv
// Directed + randomized bench for the 16-to-304 deserializer. The expected
// word is built by placing chunk k at bits [303-16k -: 16]; expected handshake
// behaviour is derived from the chunk/word protocol, not from DUT readback.
`timescale 1ns/1ps
module tb_input_module_16to304;

    localparam int CW = 16;
    localparam int NC = 19;
    localparam int WW = CW * NC;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic          ready_out;
    logic [CW-1:0] data_in;
    logic          abort;
    logic [WW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          done;
    logic [4:0]    chunk_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int max_cnt = 0;

    logic [CW-1:0] chunks [NC];
    logic [CW-1:0] pats   [4];

    input_module_16to304 dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_in    (data_in),
        .abort      (abort),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .done       (done),
        .chunk_count(chunk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference word: chunk k occupies bits [303-16k : 288-16k].
    function automatic logic [WW-1:0] exp_word();
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NC; k++)
            w[WW-1-CW*k -: CW] = chunks[k];
        return w;
    endfunction

    // Protocol monitors: count done pulses, track peak chunk_count, and flag
    // done overlapping valid_out.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (int'(chunk_count) > max_cnt) max_cnt = int'(chunk_count);
            if (done === 1'b1 && valid_out === 1'b1) begin
                errors++;
                $error("FAIL done_with_valid: got done=1 valid_out=1 expected not both");
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Deliver the word in chunks[] with random gaps, then hold for `stall`
    // cycles (optionally presenting junk chunks) before accepting it.
    task automatic run_word(input int gap_pct, input int stall, input bit junk);
        int k;
        logic [WW-1:0] exp;
        k = 0;
        exp = exp_word();
        ready_in = 1'b0;
        while (k < NC) begin
            check("collect_cnt", WW'(chunk_count), WW'(k));
            check("collect_ready", WW'(ready_out), WW'(1'b1));
            if ($urandom_range(99) < 32'(gap_pct)) begin
                valid_in = 1'b0;
                data_in  = 16'($urandom);
            end else begin
                valid_in = 1'b1;
                data_in  = chunks[k];
                k++;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("hold_valid", WW'(valid_out), WW'(1'b1));
        check("hold_data", data_out, exp);
        check("hold_cnt", WW'(chunk_count), WW'(0));
        check("hold_ready", WW'(ready_out), WW'(1'b0));
        check("hold_done", WW'(done), WW'(1'b0));
        for (int s = 0; s < stall; s++) begin
            if (junk) begin
                valid_in = 1'b1;
                data_in  = 16'h1234;
            end
            @(negedge clk);
            check("stall_valid", WW'(valid_out), WW'(1'b1));
            check("stall_data", data_out, exp);
            check("stall_ready", WW'(ready_out), WW'(1'b0));
            check("stall_cnt", WW'(chunk_count), WW'(0));
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("xfer_done", WW'(done), WW'(1'b1));
        check("xfer_valid", WW'(valid_out), WW'(1'b0));
        check("xfer_ready", WW'(ready_out), WW'(1'b1));
        check("xfer_keep_data", data_out, exp);
    endtask

    task automatic feed_chunks(input int n, input logic [CW-1:0] val);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            data_in  = val;
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] tp1_word;
        int words_done;
        tp1_word = 304'h001400140014000a000a000a000a000a000a000a000a00140014001400140014001400140014;
        pats[0] = 16'h0005; pats[1] = 16'h000a; pats[2] = 16'h000f; pats[3] = 16'h0014;

        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        abort    = 1'b0;
        ready_in = 1'b0;
        #3;
        check("rst_ready", WW'(ready_out), WW'(1'b0));
        check("rst_valid", WW'(valid_out), WW'(1'b0));
        check("rst_done", WW'(done), WW'(1'b0));
        check("rst_cnt", WW'(chunk_count), WW'(0));
        check("rst_data", data_out, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", WW'(ready_out), WW'(1'b1));

        // Back-to-back word with the downstream always ready.
        for (int k = 0; k < NC; k++)
            chunks[k] = (k < 3 || k >= 11) ? 16'h0014 : 16'h000a;
        run_word(0, 0, 1'b0);
        check("tp1_literal", data_out, tp1_word);
        @(negedge clk);
        check("tp1_done_one_cycle", WW'(done), WW'(1'b0));
        $display("txn tp1 back-to-back word delivered");

        // Ten stalled cycles with junk chunks offered during hold.
        for (int k = 0; k < NC; k++) chunks[k] = 16'h000f;
        run_word(0, 10, 1'b1);
        @(negedge clk);
        check("tp2_done_one_cycle", WW'(done), WW'(1'b0));
        for (int k = 0; k < NC; k++) chunks[k] = pats[$urandom_range(3)];
        run_word(0, 1, 1'b0);
        $display("txn tp2 stalled word and follow-up word delivered");

        // Abort after 7 chunks, colliding with a valid chunk.
        feed_chunks(7, 16'h0005);
        check("tp3_cnt7", WW'(chunk_count), WW'(7));
        abort    = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'h0014;
        @(negedge clk);
        abort    = 1'b0;
        valid_in = 1'b0;
        check("tp3_cnt_abort", WW'(chunk_count), WW'(0));
        check("tp3_ready_abort", WW'(ready_out), WW'(1'b1));
        for (int k = 0; k < NC; k++) chunks[k] = 16'h000a;
        run_word(0, 0, 1'b0);
        $display("txn tp3 abort then all-000a word delivered");

        // Sixteen random words with gaps and stalls.
        @(negedge clk);
        done_cnt = 0;
        max_cnt  = 0;
        words_done = 0;
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < NC; k++) chunks[k] = pats[$urandom_range(3)];
            run_word(30, int'($urandom_range(5)), 1'($urandom_range(1)));
            words_done++;
            $display("txn tp4 word %0d delivered %0h", w, exp_word());
        end
        @(negedge clk);
        check("tp4_done_count", WW'(done_cnt), WW'(words_done));
        check("tp4_max_cnt_le18", WW'(max_cnt <= 18), WW'(1'b1));

        // Asynchronous reset in the middle of a word.
        feed_chunks(10, 16'h000f);
        check("tp5_cnt10", WW'(chunk_count), WW'(10));
        #2;
        reset = 1'b0;
        #1;
        check("tp5a_valid", WW'(valid_out), WW'(1'b0));
        check("tp5a_done", WW'(done), WW'(1'b0));
        check("tp5a_cnt", WW'(chunk_count), WW'(0));
        check("tp5a_data", data_out, '0);
        check("tp5a_ready", WW'(ready_out), WW'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NC; k++) chunks[k] = pats[$urandom_range(3)];
        run_word(0, 2, 1'b0);
        $display("txn tp5 word after mid-word reset delivered");

        // Asynchronous reset while a word is held.
        ready_in = 1'b0;
        feed_chunks(NC, 16'h0014);
        check("tp5b_hold_valid", WW'(valid_out), WW'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check("tp5b_valid", WW'(valid_out), WW'(1'b0));
        check("tp5b_done", WW'(done), WW'(1'b0));
        check("tp5b_cnt", WW'(chunk_count), WW'(0));
        check("tp5b_data", data_out, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("tp5b_ready_after", WW'(ready_out), WW'(1'b1));
        for (int k = 0; k < NC; k++) chunks[k] = 16'(k * 3 + 1);
        run_word(20, 3, 1'b1);
        $display("txn tp5 word after hold reset delivered");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
